vga_vm_prefetch: RTL and testbench

- Video-memory read front end sitting directly upstream of the VGA display pipeline.
- Consumes the display's `vmena`/`vmaddr` word requests and returns `vmdata` one cycle later from a two-bank block buffer.
- Keeps the buffer filled by sequential prefetch and demand fetch over a single-outstanding read port to the framebuffer memory fabric.
- Misses return 0 (background pixels) and are counted; the display never stalls.

---
 rtl/vga_vm_prefetch.sv | 138 +++++++++++++
 tb/tb_vga_vm_prefetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vm_prefetch.sv
// vga_vm_prefetch: two-bank block buffer that feeds the VGA display from framebuffer memory.
// Demand fetch plus next-block prefetch into the bank not being displayed; misses read as 0.
module vga_vm_prefetch #(
    parameter int BLK_WORDS = 8,
    parameter int BLK_LOG2  = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        vmena,
    input  logic [31:0] vmaddr,
    output logic [31:0] vmdata,
    input  logic        flush,
    input  logic        miss_clr,
    output logic [15:0] miss_cnt,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data
);
    localparam int TW = 30 - BLK_LOG2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q;
    logic [31:0]         mem_q [2][BLK_WORDS];
    logic [1:0]          valid_q;
    logic [TW-1:0]       tag_q [2];
    logic [TW-1:0]       pend_blk_q;
    logic [BLK_LOG2-1:0] word_cnt_q;
    logic [31:0]         vmdata_q, rd_addr_q;
    logic [15:0]         miss_cnt_q;
    logic                mru_q, victim_q, pend_q, disc_q, rd_valid_q;

    logic [TW-1:0]       blk, next_tag, start_tag;
    logic [BLK_LOG2-1:0] off;
    logic [1:0]          hit, pend_hit;
    logic                vhit, vmiss, demand, pf, start, wr_en, unused_bits;

    assign blk         = vmaddr[31:BLK_LOG2+2];
    assign off         = vmaddr[BLK_LOG2+1:2];
    assign unused_bits = ^vmaddr[1:0];
    assign hit         = {valid_q[1] && tag_q[1] == blk, valid_q[0] && tag_q[0] == blk};
    assign pend_hit    = {valid_q[1] && tag_q[1] == pend_blk_q, valid_q[0] && tag_q[0] == pend_blk_q};
    assign vhit        = vmena && |hit;
    assign vmiss       = vmena && !(|hit);
    assign next_tag    = tag_q[mru_q] + 1'b1;
    assign demand      = pend_q && !(|pend_hit);
    assign pf          = valid_q[mru_q] && !(valid_q[!mru_q] && tag_q[!mru_q] == next_tag);
    assign start       = state_q == IDLE && (demand || pf);
    assign start_tag   = demand ? pend_blk_q : next_tag;
    assign wr_en       = state_q == WAIT && rsp_valid && !disc_q && !flush;

    assign vmdata   = vmdata_q;
    assign miss_cnt = miss_cnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_addr  = rd_addr_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[victim_q][word_cnt_q] <= rsp_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            pend_blk_q <= '0;
            word_cnt_q <= '0;
            vmdata_q   <= '0;
            rd_addr_q  <= '0;
            miss_cnt_q <= '0;
            mru_q      <= 1'b0;
            victim_q   <= 1'b0;
            pend_q     <= 1'b0;
            disc_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pend_q <= 1'b0;
                    if (start) begin
                        victim_q         <= !mru_q;
                        tag_q[!mru_q]    <= start_tag;
                        valid_q[!mru_q]  <= 1'b0;
                        word_cnt_q       <= '0;
                        rd_valid_q       <= 1'b1;
                        rd_addr_q        <= {start_tag, {BLK_LOG2{1'b0}}, 2'b00};
                        state_q          <= REQ;
                    end
                end
                REQ: if (rd_ready) begin
                    rd_valid_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: if (rsp_valid) begin
                    if (disc_q || flush) begin
                        disc_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (word_cnt_q == BLK_LOG2'(BLK_WORDS - 1)) begin
                        valid_q[victim_q] <= 1'b1;
                        state_q           <= IDLE;
                    end else begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= {tag_q[victim_q], word_cnt_q + 1'b1, 2'b00};
                        state_q    <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // a new miss overrides the pending slot consumed by IDLE this cycle
            if (vhit) begin
                vmdata_q <= mem_q[hit[1]][off];
                mru_q    <= hit[1];
            end else if (vmiss) begin
                vmdata_q   <= '0;
                pend_q     <= 1'b1;
                pend_blk_q <= blk;
            end
            if (miss_clr) miss_cnt_q <= '0;
            else if (vmiss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            // an accepted request must still have its response drained
            if (flush) begin
                valid_q    <= '0;
                pend_q     <= 1'b0;
                rd_valid_q <= 1'b0;
                if ((state_q == WAIT && !rsp_valid) || (state_q == REQ && rd_ready)) begin
                    state_q <= WAIT;
                    disc_q  <= 1'b1;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_vm_prefetch.sv
// tb_vga_vm_prefetch: directed vectors plus randomized display traffic against a
// memory-fabric model that returns a fixed nonzero function of the word address.
module tb_vga_vm_prefetch;
    logic        clk = 1'b0, rstn = 1'b0, vmena = 1'b0, flush = 1'b0, miss_clr = 1'b0;
    logic        rd_ready = 1'b0, rsp_valid = 1'b0;
    logic [31:0] vmaddr = '0, rsp_data = '0;
    logic [31:0] vmdata, rd_addr;
    logic [15:0] miss_cnt;
    logic        rd_valid;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [16];

    int checks = 0, failures = 0;
    logic [31:0] fq[$], req_log[$];
    int lat = 0, lat_max = 0;
    bit rdy_rand = 0, stall = 0, hold = 0;

    vga_vm_prefetch dut (
        .clk(clk), .rstn(rstn), .vmena(vmena), .vmaddr(vmaddr), .vmdata(vmdata),
        .flush(flush), .miss_clr(miss_clr), .miss_cnt(miss_cnt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // memory fabric: one response per accepted request, random latency
    always @(negedge clk) begin
        rsp_valid = 1'b0;
        if (!rstn) begin
            fq.delete();
            rd_ready = 1'b0;
        end else begin
            if (fq.size() > 0 && !hold) begin
                if (lat > 0) lat--;
                else begin
                    rsp_valid = 1'b1;
                    rsp_data  = fdat(fq.pop_front());
                end
            end
            rd_ready = stall ? 1'b0 : rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && rd_ready) begin
                chk("one_outstanding", 32'(fq.size()), 0);
                fq.push_back(rd_addr);
                req_log.push_back(rd_addr);
                lat = $urandom_range(0, lat_max);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a);
        vmena  = 1'b1;
        vmaddr = a;
        tick(1);
        vmena  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; vmena = 1'b0; flush = 1'b0; miss_clr = 1'b0;
        stall = 0; hold = 0; rdy_rand = 0; lat_max = 0;
        tick(2);
        rstn = 1'b1;
        req_log.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (req_log.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, 32'(req_log.size() < n ? req_log.size() : n), 32'(n));
    endtask

    initial begin
        logic [31:0] prev_data, a;
        logic [15:0] prev_cnt;
        int hits;
        bit ena;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{32'h1000 + 32'(i) * 4, fdat(32'h1000 + 32'(i) * 4), 16'd1};

        do_reset();
        chk("rst_vmdata", vmdata, 0);
        chk("rst_miss_cnt", 32'(miss_cnt), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_addr", rd_addr, 0);

        // cold start
        rd(32'h1000);
        chk("cold_vmdata", vmdata, 0);
        chk("cold_miss_cnt", 32'(miss_cnt), 1);
        wait_log(8, 200, "cold_req_count");
        tick(4);
        for (int i = 0; i < 8 && i < req_log.size(); i++)
            chk("cold_rd_addr", req_log[i], 32'h1000 + 32'(i) * 4);
        rd(32'h1008);
        chk("cold_hit_data", vmdata, fdat(32'h1008));
        chk("cold_hit_cnt", 32'(miss_cnt), 1);

        // prefetch of the next block without display requests
        req_log.delete();
        wait_log(8, 300, "pf_req_count");
        tick(4);
        for (int i = 0; i < 8 && i < req_log.size(); i++)
            chk("pf_rd_addr", req_log[i], 32'h1020 + 32'(i) * 4);
        req_log.delete();
        for (int i = 0; i < 16; i++) begin
            rd(tbl[i].addr);
            chk("seq_vmdata", vmdata, tbl[i].data);
            chk("seq_miss_cnt", 32'(miss_cnt), 32'(tbl[i].cnt));
        end

        // miss while the next prefetch is in flight
        rd(32'h8000);
        chk("mdf_vmdata", vmdata, 0);
        chk("mdf_miss_cnt", 32'(miss_cnt), 2);
        wait_log(16, 400, "mdf_req_count");
        for (int i = 0; i < 16 && i < req_log.size(); i++)
            chk("mdf_rd_addr", req_log[i], (i < 8 ? 32'h1040 : 32'h7FE0) + 32'(i) * 4);
        rd(32'h102C);
        chk("mdf_keep_data", vmdata, fdat(32'h102C));
        chk("mdf_keep_cnt", 32'(miss_cnt), 2);

        // backpressure, with reset abandoning the in-flight transaction
        do_reset();
        chk("rst2_rd_valid", 32'(rd_valid), 0);
        chk("rst2_miss_cnt", 32'(miss_cnt), 0);
        stall = 1;
        rd(32'h2000);
        for (int c = 0; c < 10 && !rd_valid; c++) tick(1);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("bp_rd_valid", 32'(rd_valid), 1);
            chk("bp_rd_addr", rd_addr, 32'h2000);
        end
        chk("bp_none_accepted", 32'(req_log.size()), 0);
        stall = 0; rdy_rand = 1; lat_max = 3;
        wait_log(8, 400, "bp_req_count");
        tick(12);
        chk("bp_exact_8", 32'(req_log.size()), 8);
        for (int i = 0; i < 8 && i < req_log.size(); i++)
            chk("bp_rd_addr_seq", req_log[i], 32'h2000 + 32'(i) * 4);
        rd(32'h2010);
        chk("bp_hit_data", vmdata, fdat(32'h2010));
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_keeps_vmdata", vmdata, fdat(32'h2010));
        chk("flush_keeps_cnt", 32'(miss_cnt), 1);
        tick(40);
        rd(32'h2010);
        chk("flushed_vmdata", vmdata, 0);
        chk("flushed_cnt", 32'(miss_cnt), 2);

        // flush while a response is pending
        do_reset();
        hold = 1;
        rd(32'h1000);
        wait_log(1, 20, "fw_first_req");
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        hold  = 0;
        tick(10);
        chk("fw_no_refetch", 32'(req_log.size()), 1);
        rd(32'h1000);
        chk("fw_vmdata", vmdata, 0);
        chk("fw_miss_cnt", 32'(miss_cnt), 2);
        wait_log(9, 300, "fw_refetch_count");
        tick(5);
        for (int i = 1; i < 9 && i < req_log.size(); i++)
            chk("fw_rd_addr", req_log[i], 32'h1000 + 32'(i - 1) * 4);
        rd(32'h1004);
        chk("fw_hit_data", vmdata, fdat(32'h1004));

        // randomized display traffic: every read is either the true word or a counted miss
        do_reset();
        rdy_rand = 1; lat_max = 1;
        hits = 0;
        a = 32'h0004_0000;
        prev_data = vmdata;
        prev_cnt  = miss_cnt;
        for (int i = 0; i < 2000; i++) begin
            ena = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 199) == 0) a = $urandom & 32'h000F_FFFC;
            if (ena) a = a + 4;
            vmena  = ena;
            vmaddr = a | 32'($urandom_range(0, 3));
            flush  = $urandom_range(0, 299) == 0;
            tick(1);
            if (ena) begin
                checks++;
                if (vmdata === fdat(a) && miss_cnt === prev_cnt) hits++;
                else if (!(vmdata === 32'h0 && miss_cnt === prev_cnt + 16'd1)) begin
                    failures++;
                    $display("FAIL rand_read addr=%h actual vmdata=%h miss_cnt=%0d required %h with miss_cnt=%0d or 0 with miss_cnt=%0d",
                             a, vmdata, miss_cnt, fdat(a), prev_cnt, prev_cnt + 16'd1);
                end
            end else begin
                chk("rand_hold_vmdata", vmdata, prev_data);
                chk("rand_hold_cnt", 32'(miss_cnt), 32'(prev_cnt));
            end
            prev_data = vmdata;
            prev_cnt  = miss_cnt;
        end
        vmena = 1'b0;
        flush = 1'b0;
        chk("rand_hits_seen", 32'(hits > 0), 1);

        // miss counter saturation and clear priority
        do_reset();
        vmena = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            vmaddr = 32'h0010_0000 + 32'(i) * 32;
            tick(1);
        end
        vmena = 1'b0;
        chk("sat_cnt", 32'(miss_cnt), 32'hFFFF);
        rd(32'h0030_0000);
        chk("sat_hold", 32'(miss_cnt), 32'hFFFF);
        miss_clr = 1'b1;
        rd(32'h0030_0020);
        miss_clr = 1'b0;
        chk("clr_over_miss", 32'(miss_cnt), 0);
        rd(32'h0030_0040);
        chk("count_after_clr", 32'(miss_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
